mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL be clocked by one clock, clk_in; reset rst_in is asynchronous and active-low.
REQ-002 Parameters: RAM_AW, default 17, byte-address width of RAM; FIFO_DEPTH, default 8, entries per UART FIFO (power of 2, at least 4).
REQ-003 Ports:
- clk_in  in  1  system clock
- rst_in  in  1  async active-low reset
- rdy_in  in  1  global ready; when low, all state holds
- mem_a  in  32  byte address from memory controller
- mem_wr  in  1  1 = write, 0 = read
- mem_dout  in  8  write data from controller
- mem_din  out  8  read data to controller
- io_buffer_full  out  1  TX FIFO near-full back-pressure
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte when tx_valid & tx_ready
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_overflow  out  1  sticky: a TX byte was dropped
- rx_overflow  out  1  sticky: an RX byte was dropped

Function
REQ-004 Address decode: IO space when mem_a[17:16]==2'b11; otherwise RAM at mem_a[RAM_AW-1:0].
REQ-005 Every access, including reads, writes and the FIFO/flag side effects in REQ-006..REQ-010, SHALL take effect only on a rising edge with rdy_in high; with rdy_in low nothing changes.
REQ-006 RAM write: on a rising edge with mem_wr=1 in RAM space, write mem_dout to RAM[mem_a[RAM_AW-1:0]].
REQ-007 RAM read: on a rising edge with mem_wr=0 in RAM space, register RAM[mem_a[RAM_AW-1:0]] into mem_din. The data is valid the cycle after the address is presented (1-cycle latency).
REQ-008 IO 0x30000 write: push mem_dout into the TX FIFO. If the FIFO is full, drop the byte and set tx_overflow.
REQ-009 IO 0x30000 read: register the RX FIFO head into mem_din and pop it. If the FIFO is empty, mem_din=8'h00 and there is no pop.
REQ-010 IO 0x30004 read: mem_din={6'b0, rx_nonempty, tx_full}.
REQ-011 Writes to any other IO address SHALL be ignored; reads from any other IO address return 8'h00.
REQ-012 io_buffer_full SHALL be registered and asserted while TX count >= FIFO_DEPTH-1, reserving one slot for a write issued in the same cycle as the check.
REQ-013 TX drain: tx_valid = TX non-empty and tx_data = TX head. On a handshake (tx_valid & tx_ready & rdy_in) pop the head.
REQ-014 RX fill: when rx_valid & rdy_in, push rx_data. If the FIFO is full, drop the byte and set rx_overflow.
REQ-015 Simultaneous push and pop on the same FIFO: both occur and count is unchanged. Push when full with a pop in the same cycle is accepted (not an overflow).
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL be log2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.
REQ-017 Overflow flags are sticky until reset.

Reset
REQ-018 While rst_in is low: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, both FIFOs empty (pointers and counts 0), tx_overflow=0, rx_overflow=0.
REQ-019 RAM contents SHALL NOT be reset.
REQ-020 Reset asserted mid-operation SHALL discard in-flight FIFO contents immediately.

Structure
REQ-021 A shared package SHALL hold: IO_BASE=32'h30000, IO_STATUS=32'h30004, the IO decode constant 2'b11, and the FIFO_DEPTH default.
REQ-022 The TX and RX queues SHALL be two instances of one sub-module, byte_fifo. It provides push/pop/full/empty/count, pass-through behaviour for simultaneous push and pop, and the async active-low reset.

Verification
REQ-023 Write 8'hA5 to 0x00123, then read 0x00123 -> mem_din=8'hA5 exactly one cycle after the read address.
REQ-024 With tx_ready=0, write 7 bytes to 0x30000 -> io_buffer_full rises after the 7th write. An 8th write is accepted. A 9th write sets tx_overflow and count stays 8.
REQ-025 Queue 3 TX bytes 8'h11, 8'h22, 8'h33, then hold tx_ready=1 -> tx_data emits 11, 22, 33 on consecutive cycles, then tx_valid=0.
REQ-026 Pulse rx_valid with 8'h42 -> reading 0x30004 gives 8'h02 (TX empty, RX non-empty). Reading 0x30000 gives 8'h42. A second read gives 8'h00.
REQ-027 Hold rdy_in=0 with mem_a=0x30000 read for 5 cycles -> no pop and mem_din unchanged. Raise rdy_in -> exactly one pop.
REQ-028 Assert rst_in low mid TX drain -> tx_valid=0 and io_buffer_full=0 immediately. After release, the FIFOs read empty and RAM data written before reset is intact.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared IO map constants and FIFO sizing for the memory/UART responder.
package mem_io_responder_pkg;
  localparam logic [31:0] IO_BASE = 32'h30000;
  localparam logic [31:0] IO_STATUS = 32'h30004;
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: byte queue with gated push/pop, full-with-pop acceptance and async active-low reset.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt,
  output logic                   drop
);
  localparam int PW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign do_pop = en & pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full queue still lands
  assign do_push = en & push & (~full | do_pop);
  assign drop = en & push & ~do_push;
  assign count_nxt = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign dout = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk_in)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART TX/RX queues behind a global ready.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tx_overflow,
  output logic        rx_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] ram [2**RAM_AW];
  logic is_io, io_data, io_stat;
  logic tx_empty, tx_full, tx_drop, rx_empty, rx_full, rx_drop;
  logic [CW-1:0] tx_count, tx_count_nxt, rx_count, rx_count_nxt;
  logic [7:0] rx_head, rd_val;
  logic unused_ok;
  assign is_io = mem_a[17:16] == IO_SEL;
  assign io_data = is_io & (mem_a == IO_BASE);
  assign io_stat = is_io & (mem_a == IO_STATUS);
  assign tx_valid = ~tx_empty;
  assign unused_ok = &{1'b0, tx_count, rx_count, rx_count_nxt, rx_full};
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk_in(clk_in), .rst_in(rst_in), .en(rdy_in), .push(mem_wr & io_data), .pop(tx_ready),
    .din(mem_dout), .dout(tx_data), .full(tx_full), .empty(tx_empty),
    .count(tx_count), .count_nxt(tx_count_nxt), .drop(tx_drop)
  );
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk_in(clk_in), .rst_in(rst_in), .en(rdy_in), .push(rx_valid), .pop(~mem_wr & io_data),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count), .count_nxt(rx_count_nxt), .drop(rx_drop)
  );
  always_comb
    rd_val = !is_io ? ram[mem_a[RAM_AW-1:0]] :
             io_data ? rx_head :
             io_stat ? {6'b0, ~rx_empty, tx_full} : 8'h00;
  always_ff @(posedge clk_in)
    if (rdy_in && mem_wr && !is_io) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din <= 8'h00;
      io_buffer_full <= 1'b0;
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
    end else if (rdy_in) begin
      if (!mem_wr) mem_din <= rd_val;
      // tracks the post-edge occupancy so the flag lines up with the count it describes
      io_buffer_full <= tx_count_nxt >= CW'(FIFO_DEPTH - 1);
      tx_overflow <= tx_overflow | tx_drop;
      rx_overflow <= rx_overflow | rx_drop;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: table vectors, directed corner sequences and random traffic against a queue model.
module tb_mem_io_responder;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, mem_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0] mem_dout = 8'h00, rx_data = 8'h00;
  logic [7:0] mem_din, tx_data;
  logic io_buffer_full, tx_valid, tx_overflow, rx_overflow;
  int n_vec = 0, n_err = 0;
  logic [7:0] tx_q[$], rx_q[$];
  logic [7:0] ram_m [int];
  logic [7:0] m_din = 8'h00;
  logic m_txo = 1'b0, m_rxo = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    tx_q.delete();
    rx_q.delete();
    m_din = 8'h00;
    m_txo = 1'b0;
    m_rxo = 1'b0;
  endfunction

  // one rising edge of the specified behaviour, evaluated on queues and an address map
  function automatic void model_step();
    logic io;
    logic txpop;
    if (!rdy_in) return;
    io = mem_a[17:16] == 2'b11;
    txpop = tx_ready && tx_q.size() > 0;
    if (!mem_wr) begin
      if (!io) m_din = ram_m[int'(mem_a[16:0])];
      else if (mem_a == 32'h30000) m_din = rx_q.size() > 0 ? rx_q.pop_front() : 8'h00;
      else if (mem_a == 32'h30004) m_din = {6'b0, rx_q.size() > 0, tx_q.size() == 8};
      else m_din = 8'h00;
    end
    if (txpop) void'(tx_q.pop_front());
    if (mem_wr && mem_a == 32'h30000) begin
      if (tx_q.size() < 8) tx_q.push_back(mem_dout);
      else m_txo = 1'b1;
    end
    if (rx_valid) begin
      if (rx_q.size() < 8) rx_q.push_back(rx_data);
      else m_rxo = 1'b1;
    end
    if (mem_wr && !io) ram_m[int'(mem_a[16:0])] = mem_dout;
  endfunction

  task automatic cmp_all();
    chk("mem_din", mem_din, m_din);
    chk("tx_valid", tx_valid, tx_q.size() > 0);
    chk("tx_data", tx_data, tx_q.size() > 0 ? tx_q[0] : 8'h00);
    chk("io_buffer_full", io_buffer_full, tx_q.size() >= 7);
    chk("tx_overflow", tx_overflow, m_txo);
    chk("rx_overflow", rx_overflow, m_rxo);
  endtask

  task automatic cyc(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d,
                     input logic txr, input logic rv, input logic [7:0] rd);
    rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
    tx_ready = txr; rx_valid = rv; rx_data = rd;
    model_step();
    @(posedge clk_in);
    #1;
    cmp_all();
  endtask

  typedef struct {
    logic [31:0] a;
    logic wr;
    logic [7:0] d;
    logic txr;
    logic rv;
    logic [7:0] rd;
    logic [7:0] e_din;
    logic e_txv;
    logic [7:0] e_txd;
    logic e_full;
  } vec_t;
  vec_t tbl[14];
  logic [31:0] addrs[8];

  initial begin
    tbl[0]  = '{32'h00123, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{32'h00123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{32'h30004, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{32'h30000, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0};
    tbl[7]  = '{32'h30000, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0};
    tbl[8]  = '{32'h30000, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0};
    tbl[9]  = '{32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0};
    tbl[10] = '{32'h30008, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0};
    tbl[11] = '{32'h30008, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 1'b0};
    tbl[12] = '{32'h00123, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{32'h00123, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
    addrs = '{32'h0, 32'h1, 32'h123, 32'hFFFF, 32'h10000, 32'h1FFFF, 32'hBEEF, 32'hABC0_1234};

    #1;
    cmp_all();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, tbl[i].a, tbl[i].wr, tbl[i].d, tbl[i].txr, tbl[i].rv, tbl[i].rd);
      chk($sformatf("tbl%0d_din", i), mem_din, tbl[i].e_din);
      chk($sformatf("tbl%0d_txv", i), tx_valid, tbl[i].e_txv);
      chk($sformatf("tbl%0d_txd", i), tx_data, tbl[i].e_txd);
      chk($sformatf("tbl%0d_full", i), io_buffer_full, tbl[i].e_full);
    end

    // fill TX to the threshold, to full, then past full
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 32'h30000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      if (i == 6) chk("full_after6", io_buffer_full, 1'b0);
      if (i == 7) chk("full_after7", io_buffer_full, 1'b1);
      if (i == 8) chk("ovf_after8", tx_overflow, 1'b0);
      if (i == 9) chk("ovf_after9", tx_overflow, 1'b1);
    end
    cyc(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("status_txfull", mem_din, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", tx_data, 32'(i));
      cyc(1'b1, 32'h00123, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    end
    chk("drain_done", tx_valid, 1'b0);

    // stalled RX read must not pop
    cyc(1'b1, 32'h00123, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC1);
    cyc(1'b1, 32'h00123, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("stall_din", mem_din, 8'hA5);
    end
    cyc(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("stall_pop1", mem_din, 8'hC1);
    cyc(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("stall_status", mem_din, 8'h02);
    cyc(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("stall_pop2", mem_din, 8'hC2);

    // reset in the middle of a TX drain
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h30000, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 32'h00123, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_full", io_buffer_full, 1'b1);
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_full", io_buffer_full, 1'b0);
    cmp_all();
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    cyc(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("post_rst_status", mem_din, 8'h00);
    cyc(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("post_rst_rx", mem_din, 8'h00);
    cyc(1'b1, 32'h00123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("post_rst_ram", mem_din, 8'hA5);

    // random traffic against the model
    foreach (addrs[i]) cyc(1'b1, addrs[i], 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 400; k++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 11);
      a = sel < 8 ? addrs[sel] : sel < 10 ? 32'h30000 : sel == 10 ? 32'h30004 : 32'h3000C;
      cyc($urandom_range(0, 9) != 0, a, 1'($urandom), 8'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
